// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//   Shared definitions for the serial-frame receive controller:
//     - state_t        : controller FSM states (IDLE, SHIFT, STOP)
//     - START_BIT      : line level that opens a frame
//     - STOP_BIT       : line level that closes a good frame
//     - cnt_width()    : bit-counter width for a given frame width
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // The counter only has to reach width-1, so clog2(width) bits suffice.
    // Never return 0 so the counter vector stays legal for tiny widths.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : sipo_pkg

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//   WIDTH-bit serial-in / parallel-out shift register. New bits enter at the
//   MSB and every bit moves one place toward bit 0 on each enabled cycle, so
//   after WIDTH shifts the first bit received sits in bit 0.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset, clears q
//   shift_en  in   shift one place when high, hold when low
//   si        in   serial data bit
//   q         out  parallel contents [WIDTH-1:0]
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {si, q[WIDTH-1:1]};
        end
    end

endmodule : sipo_shift_reg

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
//   Serial-frame receive controller. Watches a 1-bit line (one bit per clk),
//   detects a start bit, enables exactly WIDTH shifts of a SIPO register,
//   checks the stop bit and hands the captured word downstream.
//
//   Frame on the line: start (0), WIDTH data bits LSB first, stop (1).
//   Start sampled at edge 0, data at edges 1..WIDTH, stop at edge WIDTH+1;
//   out_valid is high right after edge WIDTH+1. Back-to-back frames with no
//   idle bits between them are accepted.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset; abandons any frame
//   si           in   serial data, synchronous to clk
//   out_data     out  captured word, bit 0 = first data bit received
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   consumer accepts the word
//   busy         out  FSM not in IDLE
//   frame_err    out  one-cycle pulse, stop bit was sampled as 0
//   overrun      out  sticky, a good frame arrived while a word was pending
//   clr_overrun  in   synchronous clear of overrun (a same-cycle set wins)
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// out_valid stays high and out_data stays stable until that transfer, except
// that a good frame landing on the transfer edge replaces the word in place.
// out_ready while out_valid is low is ignored.
// -----------------------------------------------------------------------------
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;

    logic shift_en;
    logic stop_good;
    logic stop_bad;
    logic accept;
    logic load;
    logic ovr_set;

    // ------------------------------------------------------------------
    // Shift register: moves only while the FSM is collecting data bits.
    // ------------------------------------------------------------------
    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .si       (si),
        .q        (shift_q)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // STOP always returns to IDLE, so a 0 seen in the stop slot is never
    // treated as the start of the next frame.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (si == START_BIT) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != IDLE);
        shift_en  = (state_q == SHIFT);
        stop_good = (state_q == STOP) && (si == STOP_BIT);
        stop_bad  = (state_q == STOP) && (si != STOP_BIT);
    end

    // ------------------------------------------------------------------
    // Bit counter: counts data bits inside SHIFT and rests at 0 elsewhere,
    // so every frame starts from 0 and the count never wraps mid-frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == SHIFT) && (cnt_q != LAST_BIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output register and flags
    // A good frame loads when the slot is empty or is being emptied on the
    // same edge; otherwise the new word is dropped and overrun is raised.
    // ------------------------------------------------------------------
    always_comb begin
        accept  = out_valid && out_ready;
        load    = stop_good && (!out_valid || out_ready);
        ovr_set = stop_good && out_valid && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= shift_q;
            out_valid <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Registered so the pulse lands in the cycle after the bad stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
        end
    end

endmodule : sipo_frame_ctrl
